// File: rtl/bsg_mcl_fifo_width_converter.sv
// bsg_mcl_fifo_width_converter: packs host words into wide FIFO words (TX) and unpacks wide words into host words (RX)
module bsg_mcl_fifo_width_converter #(
  parameter int host_width_p = 32,
  parameter int fifo_width_p = 128,
  localparam int els_lp = fifo_width_p / host_width_p,
  localparam int cw = $clog2(els_lp),
  localparam int rw = cw + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    host_tx_v_i,
  input  logic [host_width_p-1:0] host_tx_data_i,
  output logic                    host_tx_ready_o,
  output logic                    fifo_v_o,
  output logic [fifo_width_p-1:0] fifo_data_o,
  input  logic                    fifo_ready_i,
  input  logic                    fifo_v_i,
  input  logic [fifo_width_p-1:0] fifo_data_i,
  output logic                    fifo_ready_o,
  output logic                    host_rx_v_o,
  output logic [host_width_p-1:0] host_rx_data_o,
  input  logic                    host_rx_ready_i,
  output logic [cw-1:0]           tx_partial_o,
  output logic [rw-1:0]           rx_remaining_o
);
  if (els_lp < 2 || els_lp * host_width_p != fifo_width_p) begin : g_bad_ratio
    $error("fifo_width_p must be an integer multiple (>=2) of host_width_p");
  end
  logic [els_lp-1:0][host_width_p-1:0] tx_buf_r, tx_buf_n, rx_buf_r;
  logic [fifo_width_p-1:0] tx_out_r;
  logic [cw-1:0] tx_cnt_r;
  logic [rw-1:0] rx_rem_r, rx_idx;
  logic tx_full_r, tx_pend_r, tx_acc, tx_last, tx_move, tx_direct;
  // tx_out_r holds the word offered to the bridge; tx_pend_r marks a second complete word waiting in tx_buf_r
  assign host_tx_ready_o = reset_n_i & (!tx_pend_r | fifo_ready_i);
  assign tx_acc = host_tx_v_i & host_tx_ready_o;
  assign tx_last = tx_acc & (tx_cnt_r == cw'(els_lp - 1));
  assign tx_move = tx_pend_r & fifo_ready_i;
  assign tx_direct = tx_last & (!tx_full_r | fifo_ready_i);
  assign fifo_v_o = reset_n_i & tx_full_r;
  assign fifo_data_o = tx_out_r;
  assign tx_partial_o = tx_cnt_r;
  always_comb begin
    tx_buf_n = tx_buf_r;
    tx_buf_n[tx_cnt_r] = host_tx_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_cnt_r <= '0;
      tx_full_r <= 1'b0;
      tx_pend_r <= 1'b0;
    end else begin
      if (tx_acc) begin
        tx_buf_r <= tx_buf_n;
        tx_cnt_r <= tx_last ? '0 : tx_cnt_r + 1'b1;
      end
      tx_full_r <= tx_move | tx_direct | (tx_full_r & !fifo_ready_i);
      tx_pend_r <= (tx_pend_r & !fifo_ready_i) | (tx_last & !tx_direct);
      if (tx_move) tx_out_r <= tx_buf_r;
      else if (tx_direct) tx_out_r <= tx_buf_n;
    end
  end
  // slice 0 is emitted first, so the index counts up as rx_rem_r counts down
  assign host_rx_v_o = reset_n_i & (rx_rem_r != '0);
  assign fifo_ready_o = reset_n_i & ((rx_rem_r == '0) | ((rx_rem_r == rw'(1)) & host_rx_ready_i));
  assign rx_idx = rw'(els_lp) - rx_rem_r;
  assign host_rx_data_o = rx_buf_r[rx_idx[cw-1:0]];
  assign rx_remaining_o = rx_rem_r;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rx_rem_r <= '0;
    end else if (fifo_v_i & fifo_ready_o) begin
      rx_buf_r <= fifo_data_i;
      rx_rem_r <= rw'(els_lp);
    end else if (host_rx_v_o & host_rx_ready_i) begin
      rx_rem_r <= rx_rem_r - 1'b1;
    end
  end
endmodule
